// File: rtl/rv_pkg.sv
// Shared RV64 constants for the write-back path: data width, load funct3
// encodings, the hardwired-zero register and a pending-mask helper.
package rv_pkg;

  localparam int XLEN = 64;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } ld_f3_e;

  // One-hot of a destination register; x0 never shows as pending.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [4:0] r);
    logic [NUM_REGS-1:0] oh;
    oh = NUM_REGS'(1) << r;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word of an aligned doubleword and
// sign- or zero-extends it; undefined funct3 yields zero.
module load_extend
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] b_sh, h_sh, w_sh;

  // Sub-size offsets are truncated toward the natural alignment.
  assign b_sh = rdata >> {offset, 3'b000};
  assign h_sh = rdata >> {offset[2:1], 4'b0000};
  assign w_sh = rdata >> {offset[2], 5'b00000};

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:  result = {{(XLEN-8){b_sh[7]}}, b_sh[7:0]};
      F3_LH:  result = {{(XLEN-16){h_sh[15]}}, h_sh[15:0]};
      F3_LW:  result = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
      F3_LD:  result = rdata;
      F3_LBU: result = {{(XLEN-8){1'b0}}, b_sh[7:0]};
      F3_LHU: result = {{(XLEN-16){1'b0}}, h_sh[15:0]};
      F3_LWU: result = {{(XLEN-32){1'b0}}, w_sh[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back merge of ALU and load results onto one registered register-file
// write port, with one holding slot per source and load-first arbitration.
module reg_wb_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN       = rv_pkg::XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_offset,
  input  logic [XLEN-1:0] ld_rdata,
  output logic            wen,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wd,
  output logic [31:0]     pending_mask
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic            alu_full, ld_full;
  logic [4:0]      alu_rd_q, ld_rd_q;
  logic [XLEN-1:0] alu_data_q, ld_data_q, ld_ext;
  logic [CW-1:0]   starve_cnt;
  logic            starved, alu_gnt, ld_gnt, alu_acc, ld_acc;

  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3 (ld_funct3),
    .offset (ld_offset),
    .rdata  (ld_rdata),
    .result (ld_ext)
  );

  assign starved = (starve_cnt == CW'(STARVE_MAX));
  assign alu_gnt = alu_full && (!ld_full || starved);
  assign ld_gnt  = ld_full && !alu_gnt;

  // A granted slot frees this edge, so it may take a new entry at once.
  assign alu_ready = !alu_full || alu_gnt;
  assign ld_ready  = !ld_full || ld_gnt;
  assign alu_acc   = alu_valid && alu_ready;
  assign ld_acc    = ld_valid && ld_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_full   <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
    end else if (alu_acc) begin
      alu_full   <= 1'b1;
      alu_rd_q   <= alu_rd;
      alu_data_q <= alu_data;
    end else if (alu_gnt) begin
      alu_full   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_full   <= 1'b0;
      ld_rd_q   <= '0;
      ld_data_q <= '0;
    end else if (ld_acc) begin
      ld_full   <= 1'b1;
      ld_rd_q   <= ld_rd;
      ld_data_q <= ld_ext;
    end else if (ld_gnt) begin
      ld_full   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!alu_full || alu_gnt) begin
      starve_cnt <= '0;
    end else if (ld_gnt && !starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // x0 entries still take their grant cycle but never raise wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen <= 1'b0;
      rd  <= '0;
      wd  <= '0;
    end else if (alu_gnt) begin
      wen <= (alu_rd_q != REG_X0);
      rd  <= alu_rd_q;
      wd  <= alu_data_q;
    end else if (ld_gnt) begin
      wen <= (ld_rd_q != REG_X0);
      rd  <= ld_rd_q;
      wd  <= ld_data_q;
    end else begin
      wen <= 1'b0;
    end
  end

  assign pending_mask = (alu_full ? rd_onehot(alu_rd_q) : 32'd0)
                      | (ld_full  ? rd_onehot(ld_rd_q)  : 32'd0)
                      | (wen      ? rd_onehot(rd)       : 32'd0);

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed and random checks of reg_wb_ctrl against a slot/queue-level model.
module tb_reg_wb_ctrl;
  import rv_pkg::*;

  localparam int XL = 64;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, ld_valid, ld_ready, wen;
  logic [4:0]    alu_rd, ld_rd, rd;
  logic [2:0]    ld_funct3, ld_offset;
  logic [XL-1:0] alu_data, ld_rdata, wd;
  logic [31:0]   pending_mask;

  always #5 clk = ~clk;

  reg_wb_ctrl #(.XLEN(XL), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_offset(ld_offset), .ld_rdata(ld_rdata),
    .wen(wen), .rd(rd), .wd(wd), .pending_mask(pending_mask)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: each source holds at most one entry; streak = load wins while ALU waits.
  bit          m_af, m_lf, m_wen;
  logic [4:0]  m_ar, m_lr, m_rd;
  logic [63:0] m_ad, m_ldat, m_wd;
  int          m_streak;
  logic [4:0]  wr_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_af = 0; m_lf = 0; m_wen = 0; m_ar = 0; m_lr = 0; m_rd = 0;
    m_ad = 0; m_ldat = 0; m_wd = 0; m_streak = 0;
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] pm;
    pm = 0;
    if (m_af) pm[m_ar] = 1'b1;
    if (m_lf) pm[m_lr] = 1'b1;
    if (m_wen) pm[m_rd] = 1'b1;
    pm[0] = 1'b0;
    return pm;
  endfunction

  function automatic logic [63:0] ext(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] d);
    int sz, base;
    bit sgn;
    logic [63:0] v, msk;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: begin sz = 4; sgn = 1; end
      3'd3: begin sz = 8; sgn = 0; end
      3'd4: begin sz = 1; sgn = 0; end
      3'd5: begin sz = 2; sgn = 0; end
      3'd6: begin sz = 4; sgn = 0; end
      default: begin sz = 0; sgn = 0; end
    endcase
    if (sz == 0) return 64'd0;
    base = (int'(off) / sz) * sz;
    v = d >> (8 * base);
    if (sz < 8) begin
      msk = (64'd1 << (8 * sz)) - 64'd1;
      v = v & msk;
      if (sgn && v[8*sz-1]) v = v | ~msk;
    end
    return v;
  endfunction

  // Check readies, take one clock edge, advance model, check registered outputs.
  task automatic tick();
    bit ga, gl, acc_a, acc_l;
    #1;
    ga = m_af && (!m_lf || m_streak >= SM);
    gl = m_lf && !ga;
    chk("alu_ready", alu_ready, !m_af || ga);
    chk("ld_ready", ld_ready, !m_lf || gl);
    @(posedge clk);
    acc_a = alu_valid && (!m_af || ga);
    acc_l = ld_valid && (!m_lf || gl);
    if (ga) begin m_wen = (m_ar != 0); m_rd = m_ar; m_wd = m_ad; end
    else if (gl) begin m_wen = (m_lr != 0); m_rd = m_lr; m_wd = m_ldat; end
    else m_wen = 0;
    if (!m_af || ga) m_streak = 0;
    else if (gl && m_streak < SM) m_streak++;
    if (acc_a) begin m_af = 1; m_ar = alu_rd; m_ad = alu_data; end
    else if (ga) m_af = 0;
    if (acc_l) begin m_lf = 1; m_lr = ld_rd; m_ldat = ext(ld_funct3, ld_offset, ld_rdata); end
    else if (gl) m_lf = 0;
    #1;
    chk("wen", wen, m_wen);
    chk("rd", rd, m_rd);
    chk("wd", wd, m_wd);
    chk("pending_mask", pending_mask, m_pending());
    if (wen) wr_log.push_back(rd);
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [2:0] off,
                         input logic [63:0] d, input logic [63:0] exp, input string tag);
    ld_valid = 1; ld_rd = 5'd7; ld_funct3 = f3; ld_offset = off; ld_rdata = d;
    tick();
    idle();
    tick();
    chk(tag, wd, exp);
    tick();
  endtask

  initial begin
    logic [63:0] vec;
    rst = 1; idle();
    alu_rd = 0; alu_data = 0; ld_rd = 0; ld_funct3 = 0; ld_offset = 0; ld_rdata = 0;
    m_reset();
    #1;
    chk("rst_wen", wen, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wd", wd, 0);
    chk("rst_pm", pending_mask, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    #11 rst = 0;

    // ALU only, rd=5
    alu_valid = 1; alu_rd = 5'd5; alu_data = 64'h1234;
    tick();
    idle();
    chk("alu_pm5_a", pending_mask[5], 1);
    tick();
    chk("alu_wen", wen, 1);
    chk("alu_rd", rd, 5);
    chk("alu_wd", wd, 64'h1234);
    chk("alu_pm5_b", pending_mask[5], 1);
    tick();
    chk("alu_pm5_c", pending_mask[5], 0);

    // Load extension vectors
    vec = 64'h80FF_7F01_8000_00AA;
    do_load(F3_LB,  3'd0, vec, 64'hFFFF_FFFF_FFFF_FFAA, "ext_lb0");
    do_load(F3_LBU, 3'd7, vec, 64'h0000_0000_0000_0080, "ext_lbu7");
    do_load(F3_LH,  3'd2, vec, 64'hFFFF_FFFF_FFFF_8000, "ext_lh2");
    do_load(F3_LW,  3'd4, vec, 64'hFFFF_FFFF_80FF_7F01, "ext_lw4");
    do_load(F3_LWU, 3'd4, vec, 64'h0000_0000_80FF_7F01, "ext_lwu4");
    do_load(F3_LH,  3'd3, vec, 64'hFFFF_FFFF_FFFF_8000, "ext_lh3_trunc");
    do_load(F3_LD,  3'd5, vec, vec, "ext_ld");
    do_load(3'b111, 3'd0, vec, 64'd0, "ext_f3_111");

    // Collision: L,L,L,L,A repeating
    wr_log.delete();
    alu_valid = 1; alu_rd = 5'd10; alu_data = 64'hA1;
    ld_valid = 1; ld_rd = 5'd20; ld_funct3 = F3_LD; ld_rdata = 64'hB2;
    repeat (16) tick();
    idle();
    repeat (3) tick();
    chk("collide_cnt", (wr_log.size() >= 15), 1);
    if (wr_log.size() >= 15)
      for (int i = 0; i < 15; i++)
        chk("collide_seq", wr_log[i], (i % 5 == 4) ? 5'd10 : 5'd20);

    // x0 load
    ld_valid = 1; ld_rd = 5'd0; ld_funct3 = F3_LD; ld_rdata = 64'hDEAD;
    tick();
    idle();
    chk("x0_pm_a", pending_mask, 0);
    tick();
    chk("x0_wen", wen, 0);
    chk("x0_pm_b", pending_mask, 0);

    // Back-to-back ALU rd=1,2,3
    wr_log.delete();
    for (int r = 1; r <= 3; r++) begin
      alu_valid = 1; alu_rd = 5'(r); alu_data = 64'(r * 16);
      chk("b2b_ready", alu_ready, 1);
      tick();
    end
    idle();
    repeat (2) tick();
    chk("b2b_cnt", wr_log.size(), 3);
    if (wr_log.size() == 3)
      for (int i = 0; i < 3; i++) chk("b2b_seq", wr_log[i], 5'(i + 1));

    // Mid-operation reset with both slots full
    alu_valid = 1; alu_rd = 5'd9; ld_valid = 1; ld_rd = 5'd11; ld_funct3 = F3_LW;
    tick();
    rst = 1;
    #1;
    chk("mrst_wen", wen, 0);
    chk("mrst_pm", pending_mask, 0);
    chk("mrst_alu_ready", alu_ready, 1);
    chk("mrst_ld_ready", ld_ready, 1);
    idle();
    m_reset();
    @(posedge clk);
    #1 rst = 0;
    tick();
    tick();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = {$urandom, $urandom};
      ld_valid  = 1'($urandom_range(0, 1));
      ld_rd     = 5'($urandom_range(0, 31));
      ld_funct3 = 3'($urandom_range(0, 7));
      ld_offset = 3'($urandom_range(0, 7));
      ld_rdata  = {$urandom, $urandom};
      tick();
    end
    idle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
